// File: rtl/alpha_pixel_fetch.sv
// alpha_pixel_fetch: walks a pixel span, reads src1/src2 bytes, hands them to the blender, writes the result.
// Optional BLEND watchdog enabled by `define ALPHA_FETCH_TIMEOUT_EN (aborts the job and raises job_err).
module alpha_pixel_fetch #(
  parameter int ADDR_W      = 16,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src1_base,
  input  logic [ADDR_W-1:0] src2_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [CNT_W-1:0]  pixel_count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ren,
  input  logic [7:0]        mem_rdata,
  output logic              mem_wen,
  output logic [7:0]        mem_wdata,
  output logic              alpha_en,
  output logic              read_done,
  output logic [7:0]        color1,
  output logic [7:0]        color2,
  input  logic [7:0]        alpha_result,
  input  logic              alpha_done,
  output logic              busy,
  output logic              job_done,
  output logic              job_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD1, S_RD1W, S_RD2, S_RD2W, S_BLEND, S_WR, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src1_q, src1_d, src2_q, src2_d, dst_q, dst_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, idx_q, idx_d, idx_inc;
  logic [7:0]        color1_q, color1_d, color2_q, color2_d, result_q, result_d;
  logic              read_done_q, read_done_d;
  logic [ADDR_W-1:0] idx_a;

`ifdef ALPHA_FETCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
`endif

  assign idx_a = ADDR_W'(idx_q);

  always_comb begin
    state_d     = state_q;
    src1_d      = src1_q;
    src2_d      = src2_q;
    dst_d       = dst_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    idx_inc     = idx_q + 1'b1;
    color1_d    = color1_q;
    color2_d    = color2_q;
    result_d    = result_q;
    read_done_d = 1'b0;
`ifdef ALPHA_FETCH_TIMEOUT_EN
    tmo_d = '0;
    err_d = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src1_d  = src1_base;
          src2_d  = src2_base;
          dst_d   = dst_base;
          cnt_d   = pixel_count;
          idx_d   = '0;
`ifdef ALPHA_FETCH_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = (pixel_count == '0) ? S_DONE : S_RD1;
        end
      end
      S_RD1:  state_d = S_RD1W;
      S_RD1W: begin
        color1_d = mem_rdata;
        state_d  = S_RD2;
      end
      S_RD2:  state_d = S_RD2W;
      S_RD2W: begin
        color2_d    = mem_rdata;
        read_done_d = 1'b1;
        state_d     = S_BLEND;
      end
      S_BLEND: begin
        if (alpha_done) begin
          result_d = alpha_result;
          state_d  = S_WR;
        end
`ifdef ALPHA_FETCH_TIMEOUT_EN
        else begin
          // Counter is zero on the first BLEND cycle, so TIMEOUT_CYC idle cycles end in DONE.
          tmo_d = tmo_q + 1'b1;
          if (tmo_q == TMO_LAST) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
`endif
      end
      S_WR: begin
        idx_d   = idx_inc;
        state_d = (idx_inc == cnt_q) ? S_DONE : S_RD1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Memory strobes are decoded from state so reset drops them immediately.
  always_comb begin
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      S_RD1: begin
        mem_ren  = 1'b1;
        mem_addr = src1_q + idx_a;
      end
      S_RD2: begin
        mem_ren  = 1'b1;
        mem_addr = src2_q + idx_a;
      end
      S_WR: begin
        mem_wen   = 1'b1;
        mem_addr  = dst_q + idx_a;
        mem_wdata = result_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      src1_q      <= '0;
      src2_q      <= '0;
      dst_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      color1_q    <= '0;
      color2_q    <= '0;
      result_q    <= '0;
      read_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
      dst_q       <= dst_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      color1_q    <= color1_d;
      color2_q    <= color2_d;
      result_q    <= result_d;
      read_done_q <= read_done_d;
    end
  end

`ifdef ALPHA_FETCH_TIMEOUT_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
  assign job_err = err_q;
`else
  assign job_err = 1'b0;
`endif

  assign busy      = (state_q != S_IDLE);
  assign alpha_en  = busy;
  assign job_done  = (state_q == S_DONE);
  assign read_done = read_done_q;
  assign color1    = color1_q;
  assign color2    = color2_q;

endmodule

// File: tb/tb_alpha_pixel_fetch.sv
// Bench for alpha_pixel_fetch: event-timing reference model checked every cycle, plus literal scenario checks.
module tb_alpha_pixel_fetch;
  localparam int TMO   = 64;
  localparam int BOUND = 4000;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] src1_base = '0, src2_base = '0, dst_base = '0, pixel_count = '0;
  logic [15:0] mem_addr;
  logic        mem_ren, mem_wen;
  logic [7:0]  mem_rdata = '0;
  logic [7:0]  mem_wdata;
  logic        alpha_en, read_done, busy, job_done, job_err;
  logic [7:0]  color1, color2;
  logic [7:0]  alpha_result = '0;
  logic        alpha_done = 1'b0;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem [0:65535];

  alpha_pixel_fetch #(.ADDR_W(16), .CNT_W(16), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .n_rst(n_rst), .start(start),
    .src1_base(src1_base), .src2_base(src2_base), .dst_base(dst_base), .pixel_count(pixel_count),
    .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_rdata(mem_rdata),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .alpha_en(alpha_en), .read_done(read_done), .color1(color1), .color2(color2),
    .alpha_result(alpha_result), .alpha_done(alpha_done),
    .busy(busy), .job_done(job_done), .job_err(job_err)
  );

  always #5 clk = ~clk;

  // Frame buffer: one-cycle read latency, write takes effect at the strobe edge.
  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= mem[mem_addr];
    if (mem_wen) mem[mem_addr] = mem_wdata;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Blender stand-in: 0 random, 1 held high, 2 never, 3 done 2 cycles after read_done with A0+n
  int mode = 0;
  int dly = 0;
  int pix = 0;
  always @(posedge clk) begin
    #1;
    case (mode)
      0: begin alpha_done = ($urandom_range(0, 3) == 0); alpha_result = 8'($urandom); end
      1: begin alpha_done = 1'b1; alpha_result = 8'($urandom); end
      2: begin alpha_done = 1'b0; alpha_result = 8'($urandom); end
      default: begin
        alpha_done = 1'b0;
        if (read_done) dly = 2;
        else if (dly > 0) begin
          dly--;
          if (dly == 0) begin
            alpha_done   = 1'b1;
            alpha_result = 8'(8'hA0 + pix);
            pix++;
          end
        end
      end
    endcase
  end

  // Reference model: tracks the job as a sequence of expected event cycles.
  int          cyc = 0;
  logic        mbusy = 1'b0, merr = 1'b0, pend = 1'b0;
  int          e_ren1 = -1, e_ren2 = -1, e_rd = -1, e_wen = -1, e_done = -1, bcnt = 0;
  logic [15:0] m_s1, m_s2, m_d, m_cnt, m_idx;
  logic [7:0]  m_wd, m_c1, m_c2;
  int          acc_cyc = 0, done_cyc = 0, rd_cyc = 0, rd_cnt = 0, jd_cnt = 0;
  logic [15:0] ren_log[$];
  logic [15:0] wen_log[$];

  always @(negedge clk) begin : cmp
    logic [15:0] a;
    logic        cur_busy;
    cyc++;
    if (!n_rst) begin
      chk("reset_outputs", {mem_addr, mem_ren, mem_wen, mem_wdata, alpha_en, read_done,
                            color1, color2, busy, job_done, job_err}, 64'd0);
      mbusy = 1'b0; merr = 1'b0; pend = 1'b0;
      e_ren1 = -1; e_ren2 = -1; e_rd = -1; e_wen = -1; e_done = -1;
    end else begin
      cur_busy = mbusy;
      if (mem_ren) ren_log.push_back(mem_addr);
      if (mem_wen) wen_log.push_back(mem_addr);
      if (read_done) begin rd_cnt++; rd_cyc = cyc; end
      if (job_done) begin jd_cnt++; done_cyc = cyc; end

      chk("ren_wen_exclusive", mem_ren & mem_wen, 0);
      if (!mem_ren && !mem_wen) chk("addr_idle_zero", mem_addr, 0);
      chk("busy", busy, cur_busy);
      chk("alpha_en", alpha_en, cur_busy);
      chk("job_err", job_err, merr);
      chk("ren_timing", mem_ren, (cyc == e_ren1) || (cyc == e_ren2));
      chk("read_done_timing", read_done, cyc == e_rd);
      chk("wen_timing", mem_wen, cyc == e_wen);
      chk("job_done_timing", job_done, cyc == e_done);

      if (cyc == e_ren1) begin
        a = m_s1 + m_idx;
        chk("src1_addr", mem_addr, a);
        m_c1 = mem[a];
      end
      if (cyc == e_ren2) begin
        a = m_s2 + m_idx;
        chk("src2_addr", mem_addr, a);
        m_c2 = mem[a];
      end
      if (cyc == e_rd) begin
        chk("color1", color1, m_c1);
        chk("color2", color2, m_c2);
        pend = 1'b1;
        bcnt = 0;
      end
      if (pend) begin
        if (alpha_done) begin
          m_wd  = alpha_result;
          e_wen = cyc + 1;
          pend  = 1'b0;
        end else begin
          bcnt++;
`ifdef ALPHA_FETCH_TIMEOUT_EN
          if (bcnt == TMO) begin
            pend   = 1'b0;
            e_done = cyc + 1;
            merr   = 1'b1;
          end
`endif
        end
      end
      if (cyc == e_wen) begin
        a = m_d + m_idx;
        chk("dst_addr", mem_addr, a);
        chk("wdata", mem_wdata, m_wd);
        chk("color1_hold", color1, m_c1);
        chk("color2_hold", color2, m_c2);
        m_idx++;
        if (m_idx == m_cnt) e_done = cyc + 1;
        else begin e_ren1 = cyc + 1; e_ren2 = cyc + 3; e_rd = cyc + 5; end
      end
      if (cyc == e_done) mbusy = 1'b0;
      if (!cur_busy && start) begin
        m_s1 = src1_base; m_s2 = src2_base; m_d = dst_base; m_cnt = pixel_count;
        m_idx = '0; mbusy = 1'b1; merr = 1'b0; acc_cyc = cyc;
        if (pixel_count == 16'd0) e_done = cyc + 1;
        else begin e_ren1 = cyc + 1; e_ren2 = cyc + 3; e_rd = cyc + 5; end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_logs();
    ren_log.delete();
    wen_log.delete();
    rd_cnt = 0;
    jd_cnt = 0;
  endtask

  task automatic run_job(input logic [15:0] s1, input logic [15:0] s2, input logic [15:0] d,
                         input logic [15:0] cnt, input bit spur);
    int k;
    src1_base = s1; src2_base = s2; dst_base = d; pixel_count = cnt; start = 1'b1;
    tick(1);
    start = 1'b0;
    src1_base = 16'($urandom); src2_base = 16'($urandom);
    dst_base = 16'($urandom); pixel_count = 16'($urandom);
    k = 0;
    while (!job_done && k < BOUND) begin
      start = spur && ($urandom_range(0, 3) == 0);
      tick(1);
      k++;
    end
    start = 1'b0;
    chk("job_completes_in_bound", k < BOUND, 1);
    tick(2);
  endtask

  initial begin
    int k;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    tick(3);
    chk("reset_busy", busy, 0);
    chk("reset_job_done", job_done, 0);
    n_rst = 1'b1;
    tick(2);

    // Reset while waiting in BLEND abandons the job
    mode = 2;
    clr_logs();
    src1_base = 16'h0040; src2_base = 16'h0050; dst_base = 16'h0060; pixel_count = 16'd2;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    k = 0;
    while (!read_done && k < 50) begin tick(1); k++; end
    chk("reach_blend", read_done, 1);
    tick(3);
    #1 n_rst = 1'b0;
    #1;
    chk("async_rst_outs", {mem_addr, mem_ren, mem_wen, alpha_en, read_done, color1, color2,
                           busy, job_done, job_err}, 64'd0);
    tick(3);
    n_rst = 1'b1;
    tick(1);
    chk("rst_no_write", wen_log.size(), 0);
    chk("rst_no_job_done", jd_cnt, 0);
    mode = 0;
    clr_logs();
    run_job(16'h0400, 16'h0500, 16'h0600, 16'd2, 1'b0);
    chk("post_rst_job_writes", wen_log.size(), 2);

    // Three pixels, result = A0 + index
    mode = 3; pix = 0; dly = 0;
    clr_logs();
    run_job(16'h0100, 16'h0200, 16'h0300, 16'd3, 1'b0);
    chk("t2_mem300", mem[16'h0300], 8'hA0);
    chk("t2_mem301", mem[16'h0301], 8'hA1);
    chk("t2_mem302", mem[16'h0302], 8'hA2);
    chk("t2_writes", wen_log.size(), 3);
    chk("t2_job_done_count", jd_cnt, 1);

    // Empty job: done right away, no memory traffic
    mode = 0;
    clr_logs();
    run_job(16'h1111, 16'h2222, 16'h3333, 16'd0, 1'b0);
    chk("cnt0_latency", done_cyc - acc_cyc, 1);
    chk("cnt0_no_ren", ren_log.size(), 0);
    chk("cnt0_no_wen", wen_log.size(), 0);

    // Source address wraps past 0xFFFF
    clr_logs();
    run_job(16'hFFFF, 16'h0800, 16'h0900, 16'd2, 1'b0);
    chk("wrap_ren_count", ren_log.size(), 4);
    if (ren_log.size() == 4) begin
      chk("wrap_first", ren_log[0], 16'hFFFF);
      chk("wrap_second", ren_log[2], 16'h0000);
    end

    // alpha_done held high from reset; stray starts during the job
    mode = 1;
    n_rst = 1'b0;
    tick(2);
    n_rst = 1'b1;
    tick(2);
    clr_logs();
    run_job(16'h0A00, 16'h0B00, 16'h0C00, 16'd4, 1'b1);
    chk("t5_read_done_count", rd_cnt, 4);
    chk("t5_job_done_count", jd_cnt, 1);
    chk("t5_writes", wen_log.size(), 4);

    // Randomized jobs
    mode = 0;
    for (int j = 0; j < 8; j++) begin
      clr_logs();
      run_job(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom_range(1, 5)), 1'b1);
      chk("rand_job_done_count", jd_cnt, 1);
    end

`ifdef ALPHA_FETCH_TIMEOUT_EN
    mode = 2;
    clr_logs();
    run_job(16'h1000, 16'h2000, 16'h3000, 16'd2, 1'b0);
    chk("tmo_latency", done_cyc - rd_cyc, TMO);
    chk("tmo_no_wen", wen_log.size(), 0);
    chk("tmo_err", job_err, 1);
    tick(5);
    chk("tmo_err_hold", job_err, 1);
    mode = 0;
    run_job(16'h1000, 16'h2000, 16'h3000, 16'd1, 1'b0);
    chk("tmo_err_cleared", job_err, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

endmodule
